// File: rtl/vga_raster_gen.sv
// VGA raster timing and picture-ROM address generator (pixel strobe, h/v counters, sync/blank decode).
// Define VGA_PIPE_EN to delay the decoded outputs by one pixel to line up with a registered ROM.
module vga_raster_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIDTH    = 480,
    parameter int HEIGHT   = 320,
    parameter int ADDR_W   = 18
) (
    input  logic              vga_clk,
    input  logic              reset,
    output logic              pix_en,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              in_image,
    output logic [9:0]        x,
    output logic [9:0]        y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] IMG_W      = 10'(WIDTH);
    localparam logic [9:0] IMG_H      = 10'(HEIGHT);
    localparam logic [9:0] IMG_W_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] IMG_H_LAST = 10'(HEIGHT - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [9:0]        h_cnt_q, h_cnt_d;
    logic [9:0]        v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic pix_tick, h_wrap, v_wrap, last_img_px;
    logic hsync_c, vsync_c, active_c, in_image_c;

    // Decode straight from the registered counters.
    always_comb begin
        pix_tick    = (div_q == DIV_LAST) && !reset;
        h_wrap      = (h_cnt_q == H_LAST);
        v_wrap      = (v_cnt_q == V_LAST);
        hsync_c     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vsync_c     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        active_c    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_image_c  = (h_cnt_q < IMG_W) && (v_cnt_q < IMG_H);
        last_img_px = (h_cnt_q == IMG_W_LAST) && (v_cnt_q == IMG_H_LAST);
    end

    // NOTE: every signal gets a default before the conditionals so no latch is inferred.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        addr_d  = addr_q;
        if (pix_tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
            end
            // Address steps with the raster; it parks on the last picture pixel until frame wrap.
            if (h_wrap && v_wrap) begin
                addr_d = '0;
            end else if (in_image_c && !last_img_px) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            addr_q  <= '0;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign pix_en   = pix_tick;
    assign x        = h_cnt_q;
    assign y        = v_cnt_q;
    assign rom_addr = addr_q;

`ifdef VGA_PIPE_EN
    logic hsync_q, vsync_q, active_q, in_image_q, frame_end_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            active_q    <= 1'b1;
            in_image_q  <= 1'b1;
            frame_end_q <= 1'b0;
        end else if (pix_tick) begin
            hsync_q     <= hsync_c;
            vsync_q     <= vsync_c;
            active_q    <= active_c;
            in_image_q  <= in_image_c;
            frame_end_q <= h_wrap && v_wrap;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign active    = active_q;
    assign in_image  = in_image_q;
    assign frame_end = pix_tick && frame_end_q;
`else
    assign hsync     = hsync_c;
    assign vsync     = vsync_c;
    assign active    = active_c;
    assign in_image  = in_image_c;
    assign frame_end = pix_tick && h_wrap && v_wrap;
`endif

endmodule

// File: tb/tb_vga_raster_gen.sv
// Scoreboard bench for vga_raster_gen on a shrunken raster (24x13 total, 10x6 picture, CLK_DIV=2).
// Expected pixel tuples are queued by the stimulus; a monitor pops one per pix_en strobe.
module tb_vga_raster_gen;

    localparam int CLK_DIV = 2;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
    localparam int W  = 10, H = 6, AW = 8;
    localparam int HT = HA + HFP + HS + HBP;   // 24
    localparam int VT = VA + VFP + VS + VBP;   // 13
    localparam int FRAME_PIX = HT * VT;        // 312

    typedef struct packed {
        logic [9:0]    x;
        logic [9:0]    y;
        logic          hs;
        logic          vs;
        logic          act;
        logic          img;
        logic [AW-1:0] addr;
        logic          fe;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pix_en, hsync, vsync, active, in_image, frame_end;
    logic [9:0]    x, y;
    logic [AW-1:0] rom_addr;

    int   checks = 0;
    int   failures = 0;
    pix_t exp_q[$];
    bit   armed = 1'b0;
    int   cyc = 0;

    vga_raster_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)
    ) dut (
        .vga_clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .active(active), .in_image(in_image), .x(x), .y(y), .rom_addr(rom_addr),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address the ROM should show at (h,v): linear inside the picture, parked afterwards.
    function automatic int addr_at(input int h, input int v);
        if (v >= H)     return W * H - 1;
        if (h < W)      return v * W + h;
        if (v == H - 1) return W * H - 1;
        return v * W + W;
    endfunction

    // Expected outputs during the k-th pixel strobe after reset release.
    function automatic pix_t model(input int k);
        pix_t e;
        int h, v, ph, pv;
        h = k % HT;
        v = (k / HT) % VT;
`ifdef VGA_PIPE_EN
        ph = (k == 0) ? 0 : (k - 1) % HT;
        pv = (k == 0) ? 0 : ((k - 1) / HT) % VT;
`else
        ph = h;
        pv = v;
`endif
        e.x    = 10'(h);
        e.y    = 10'(v);
        e.addr = AW'(addr_at(h, v));
        e.hs   = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
        e.vs   = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
        e.act  = (ph < HA) && (pv < VA);
        e.img  = (ph < W) && (pv < H);
        e.fe   = (ph == HT - 1) && (pv == VT - 1);
        return e;
    endfunction

    task automatic push_pixels(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(model(k));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},        64'(x), 64'd0);
        check({tag, "_y"},        64'(y), 64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_hsync"},    64'(hsync), 64'd1);
        check({tag, "_vsync"},    64'(vsync), 64'd1);
        check({tag, "_active"},   64'(active), 64'd1);
        check({tag, "_in_image"}, 64'(in_image), 64'd1);
        check({tag, "_pix_en"},   64'(pix_en), 64'd0);
        check({tag, "_frame_end"},64'(frame_end), 64'd0);
    endtask

    // Monitor: strobe cadence every cycle, scoreboard pop on every pix_en.
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            check("pix_en_in_reset", 64'(pix_en), 64'd0);
        end else begin
            check("pix_en_cadence", 64'(pix_en), 64'((cyc % CLK_DIV) == CLK_DIV - 1));
            cyc++;
            if (frame_end && !pix_en) check("frame_end_without_pix_en", 64'd1, 64'd0);
            if (pix_en && armed) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 64'd1, 64'd0);
                end else begin
                    pix_t e, a;
                    e = exp_q.pop_front();
                    a = '{x: x, y: y, hs: hsync, vs: vsync, act: active, img: in_image,
                          addr: rom_addr, fe: frame_end};
                    check("pixel{x,y,hs,vs,act,img,addr,fe}", 64'(a), 64'(e));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        armed = 1'b1;
        push_pixels(2 * FRAME_PIX + 1);
        reset = 1'b0;
        drain("drain_two_frames");
        check("after_frames_x", 64'(x), 64'd1);
        check("after_frames_y", 64'(y), 64'd0);

        // Mid-frame reset: run to (5,3), i.e. pixel 77, then pulse reset for one cycle.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_pixels(3 * HT + 5);
        drain("drain_to_mid_frame");
        check("mid_x", 64'(x), 64'd5);
        check("mid_y", 64'(y), 64'd3);
        check("mid_rom_addr", 64'(rom_addr), 64'd35);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        push_pixels(2 * FRAME_PIX);
        reset = 1'b0;
        drain("drain_after_mid_reset");
        armed = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_raster_gen.md
Name: vga_raster_gen

Overview:
- Raster timing and pixel-address generator for the VGA display path.
- Sits directly upstream of the VGA output stage, in the same fast clock domain (50 MHz on DE0).
- Divides the clock into a pixel strobe and runs horizontal/vertical counters to produce sync, blanking and screen coordinates.
- Produces a linear read address into the picture ROM for a WIDTH x HEIGHT image anchored at screen top-left.

Parameters:
- CLK_DIV, 2, fast-clock cycles per pixel (>=1); 2 gives 25 MHz from 50 MHz.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, pixels.
- H_SYNC, 96, hsync pulse width, pixels.
- H_BP, 48, horizontal back porch, pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch, lines.
- V_SYNC, 2, vsync pulse width, lines.
- V_BP, 33, vertical back porch, lines.
- WIDTH, 480, picture width, pixels (<= H_ACTIVE).
- HEIGHT, 320, picture height, lines (<= V_ACTIVE).
- ADDR_W, 18, ROM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- vga_clk, input, 1, fast clock; every register is clocked on its rising edge.
- reset, input, 1, synchronous, active-high.
- pix_en, output, 1, one-cycle pixel strobe, high once every CLK_DIV cycles.
- hsync, output, 1, horizontal sync, active low.
- vsync, output, 1, vertical sync, active low.
- active, output, 1, high inside the H_ACTIVE x V_ACTIVE visible region.
- in_image, output, 1, high inside the WIDTH x HEIGHT picture region.
- x, output, 10, current horizontal count.
- y, output, 10, current vertical count.
- rom_addr, output, ADDR_W, picture ROM address.
- frame_end, output, 1, one-cycle strobe marking the last pixel of a frame.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1 every cycle, then wraps to 0.
  - pix_en = (div == CLK_DIV-1).
  - With CLK_DIV=1, pix_en is constantly high after reset.
- Counters: h_cnt and v_cnt advance only in cycles where pix_en is high.
  - h_cnt: 0..H_TOTAL-1, then wraps to 0.
  - v_cnt: increments when h_cnt wraps; wraps to 0 from V_TOTAL-1.
- x = h_cnt and y = v_cnt, taken directly from the registers.
- Decode, from the registered counters:
  - hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - in_image = (h_cnt < WIDTH) && (v_cnt < HEIGHT).
- rom_addr:
  - Register; must equal v_cnt*WIDTH + h_cnt whenever in_image is high.
  - Implemented incrementally; no multiplier.
  - Increments by 1 on each pix_en cycle where in_image is high.
  - Holds outside the picture region.
  - Cleared to 0 on the pix_en cycle where the counters wrap from (H_TOTAL-1, V_TOTAL-1).
- frame_end = pix_en && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1.
- Reset (applies mid-frame as well):
  - div=0, h_cnt=0, v_cnt=0, rom_addr=0.
  - hsync=1, vsync=1, pix_en=0, frame_end=0.
  - active=1 and in_image=1, since (0,0) decodes as visible.
  - Raster restarts cleanly at (0,0) on the first cycle after reset deasserts; no partial line is emitted.
- Simultaneous events: a line wrap and a frame wrap on the same pix_en both take effect in that single cycle.
- Latency: all decoded outputs follow counter updates combinationally within the same cycle.

Optional Feature:
- Macro: VGA_PIPE_EN.
- Defined:
  - hsync, vsync, active, in_image and frame_end are delayed by exactly one pixel period. The delay register loads on pix_en; frame_end stays a single-cycle pulse.
  - This aligns them with picture data from a ROM registered on rom_addr.
  - x, y and rom_addr are not delayed.
  - Delay registers reset to the undelayed reset values.
- Undefined: no delay stage; outputs behave as in Behaviour.

Test Plan:
- Reset held 3 cycles, then released -> pix_en first high on cycle 2 after release (CLK_DIV=2), then every 2 cycles; x=0, y=0, hsync=1, vsync=1, rom_addr=0 at release.
- Run one line -> hsync low for exactly 96 pixel strobes (192 clocks), starting when x=656; line length 1600 clocks; y increments when x wraps 799->0.
- Run one full frame -> vsync low only on y=490 and y=491; frame_end pulses once per 840000 clocks; x=0, y=0 afterwards.
- Picture addressing -> rom_addr=479 at (479,0); 480 at (0,1); 153599 at (479,319); holds at 153599 outside the picture; returns to 0 at the frame wrap.
- Assert reset at x=300, y=200 for 1 cycle -> next cycle x=0, y=0, rom_addr=0, div=0; the following frame's timing is identical to the first.
- With VGA_PIPE_EN defined -> hsync falls one pix_en after x reaches 656; in_image deasserts one pixel after x=480; x and rom_addr timing unchanged from the undefined build.
